// File: rtl/dgiota_pkg.sv
// Shared types and constants for the dgiota UART paths.
package dgiota_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

   localparam int unsigned DGIOTA_UART_DATA_BITS            = 8;
   localparam int unsigned DGIOTA_UART_DEFAULT_CLKS_PER_BIT = 16;

   // Divider width: $clog2 of the bit period, never narrower than one bit.
   function automatic int unsigned dgiota_cnt_width(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dgiota_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1, tick at the terminal count.
module dgiota_baud_tick
   import dgiota_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DGIOTA_UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int unsigned   CW   = dgiota_cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || restart || (r_count == LAST)) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

   assign tick = (r_count == LAST);

endmodule

// File: rtl/dgiota_uart_tx.sv
// 8N1 LSB-first UART transmitter with valid/ready byte input and pin output enable.
module dgiota_uart_tx
   import dgiota_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DGIOTA_UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DGIOTA_UART_DATA_BITS-1:0] tx_data,
   input  logic                             tx_valid,
   output logic                             tx_ready,
   output logic                             tx_busy,
   output logic                             tx_out,
   output logic                             tx_oe
);

   if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > 65535)) begin : g_bad_cfg
      $error("dgiota_uart_tx: CLKS_PER_BIT must be in 2..65535");
   end

   localparam logic [2:0] LAST_BIT = 3'(DGIOTA_UART_DATA_BITS - 1);

   uart_tx_state_t                   r_state;
   logic [DGIOTA_UART_DATA_BITS-1:0] r_shift;
   logic [2:0]                       r_bitcnt;
   logic                             r_tx_out;
   logic                             r_oe;
   logic                             r_ready;
   logic                             r_busy;
   logic                             w_tick;
   logic                             w_restart;

   // Holding the divider at zero through IDLE makes the accept cycle its restart.
   assign w_restart = (r_state == IDLE);

   dgiota_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .restart(w_restart),
      .tick   (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_bitcnt <= '0;
         r_tx_out <= 1'b1;
         r_oe     <= 1'b0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_oe <= 1'b1;
         unique case (r_state)
            IDLE: begin
               if (tx_valid && r_ready) begin
                  r_shift  <= tx_data;
                  r_bitcnt <= '0;
                  r_tx_out <= 1'b0;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= START;
               end else begin
                  // r_oe lags reset release by one edge, giving the one-cycle ready hold-off.
                  r_ready <= r_oe;
               end
            end
            START: begin
               if (w_tick) begin
                  r_tx_out <= r_shift[0];
                  r_shift  <= r_shift >> 1;
                  r_state  <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_bitcnt == LAST_BIT) begin
                     r_tx_out <= 1'b1;
                     r_state  <= STOP;
                  end else begin
                     r_tx_out <= r_shift[0];
                     r_shift  <= r_shift >> 1;
                     r_bitcnt <= r_bitcnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (w_tick) begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign tx_out   = r_tx_out;
   assign tx_oe    = r_oe;
   assign tx_ready = r_ready;
   assign tx_busy  = r_busy;

endmodule

// File: tb/tb_dgiota_uart_tx.sv
// Scoreboard bench for dgiota_uart_tx with CLKS_PER_BIT=4.
module tb_dgiota_uart_tx;

   localparam int N = 4;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_out;
   logic       tx_oe;

   dgiota_uart_tx #(
      .CLKS_PER_BIT(N)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_busy (tx_busy),
      .tx_out  (tx_out),
      .tx_oe   (tx_oe)
   );

   typedef struct {
      logic [7:0] d;
      int         start;
      bit         abrt;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: reconstructs frames from the line and checks them against the scoreboard.
   bit         in_frame = 0;
   exp_t       cur;
   int         f_start;
   int         f_bad;
   logic [9:0] f_exp;
   logic [7:0] f_rx;

   always @(negedge clk) begin
      int pos;
      int bi;
      if (in_frame && rst) begin
         chk("abort_expected", 32'(cur.abrt), 32'd1);
         in_frame = 0;
      end else if (in_frame) begin
         pos = cyc - f_start;
         bi  = pos / N;
         if (tx_out !== f_exp[bi]) f_bad++;
         if ((pos % N == N / 2) && (bi >= 1) && (bi <= 8)) f_rx[bi-1] = tx_out;
         if (pos == 10 * N - 1) begin
            chk("frame_byte", 32'(f_rx), 32'(cur.d));
            chk("frame_bad_cycles", 32'(f_bad), 32'd0);
            chk("frame_not_aborted", 32'(cur.abrt), 32'd0);
            in_frame = 0;
         end
      end else if (!rst && tx_oe === 1'b1 && tx_out === 1'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
         end else begin
            cur      = sb.pop_front();
            in_frame = 1;
            f_start  = cyc;
            f_bad    = 0;
            f_rx     = '0;
            f_exp    = {1'b1, cur.d, 1'b0};
            chk("start_cycle", 32'(cyc), 32'(cur.start));
         end
      end
   end

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int k);
      while (cyc < k) tick1();
   endtask

   // Presents a byte and returns the accept cycle; the start bit is expected one cycle later.
   task automatic send(input logic [7:0] d, input bit hold, input bit abrt, output int t);
      int   n;
      exp_t e;
      tx_data  = d;
      tx_valid = 1'b1;
      n = 0;
      while (tx_ready !== 1'b1 && n < 200) begin
         tick1();
         n++;
      end
      t = cyc;
      if (n >= 200) chk("accept_timeout", 32'd1, 32'd0);
      e.d = d;
      e.start = t + 1;
      e.abrt = abrt;
      sb.push_back(e);
      tick1();
      if (!hold) tx_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

   initial begin
      int t, t2;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;

      // Reset behaviour
      repeat (3) tick1();
      chk("rst_tx_out", 32'(tx_out), 32'd1);
      chk("rst_tx_oe", 32'(tx_oe), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd0);
      chk("rst_tx_busy", 32'(tx_busy), 32'd0);
      rst = 1'b0;
      tick1();
      chk("post_rst_oe", 32'(tx_oe), 32'd1);
      chk("post_rst_ready_holdoff", 32'(tx_ready), 32'd0);
      tick1();
      chk("post_rst_ready", 32'(tx_ready), 32'd1);

      // Single byte 0xA5
      send(8'hA5, 0, 0, t);
      chk("a5_busy", 32'(tx_busy), 32'd1);
      chk("a5_ready_low", 32'(tx_ready), 32'd0);
      wait_until(t + 40);
      chk("a5_ready_t40", 32'(tx_ready), 32'd0);
      chk("a5_stop_t40", 32'(tx_out), 32'd1);
      wait_until(t + 41);
      chk("a5_ready_t41", 32'(tx_ready), 32'd1);
      chk("a5_busy_t41", 32'(tx_busy), 32'd0);
      repeat (3) tick1();

      // Back-to-back 0x00 then 0xFF with valid held
      send(8'h00, 1, 0, t);
      send(8'hFF, 0, 0, t2);
      chk("b2b_second_accept", 32'(t2), 32'(t + 41));
      wait_until(t2 + 41);
      repeat (2) tick1();

      // Data changed after accept
      send(8'h81, 0, 0, t);
      wait_until(t + 5);
      tx_data = 8'h3C;
      wait_until(t + 43);

      // Reset mid-frame
      send(8'h5A, 0, 1, t);
      wait_until(t + 20);
      rst = 1'b1;
      tick1();
      rst = 1'b0;
      chk("midrst_tx_out", 32'(tx_out), 32'd1);
      chk("midrst_busy", 32'(tx_busy), 32'd0);
      chk("midrst_oe", 32'(tx_oe), 32'd0);
      send(8'hC3, 0, 0, t);
      wait_until(t + 43);

      // Valid pulsed during STOP is ignored
      send(8'h33, 0, 0, t);
      wait_until(t + 38);
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      chk("busy_ready_low", 32'(tx_ready), 32'd0);
      tick1();
      tx_valid = 1'b0;
      wait_until(t + 50);
      chk("busy_no_accept", 32'(tx_busy), 32'd0);
      send(8'h55, 0, 0, t);
      wait_until(t + 43);

      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      chk("monitor_idle", 32'(in_frame), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
